text_console_writer: RTL and testbench
======================================

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 SHALL have parameter COL_BITS, default 7: column index width; 2**COL_BITS columns per row (128).
REQ-002 SHALL have parameter ROW_BITS, default 6: row index width.
REQ-003 SHALL have parameter NUM_ROWS, default 48: rows in use, indices 0..NUM_ROWS-1, NUM_ROWS <= 2**ROW_BITS.
REQ-004 SHALL have parameter DATA_WIDTH, default 8: character code width.
REQ-005 SHALL have port clk, input, 1: the single clock; every register updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_char, input, DATA_WIDTH: character code offered by the producer.
REQ-008 SHALL have port in_valid, input, 1: in_char is valid.
REQ-009 SHALL have port in_ready, output, 1: the block can accept a character this cycle.
REQ-010 SHALL have port ram_we, output, 1: write enable to the text RAM write port.
REQ-011 SHALL have port ram_addr, output, ROW_BITS+COL_BITS: write address {row, col}.
REQ-012 SHALL have port ram_din, output, DATA_WIDTH: write data.
REQ-013 SHALL have port cursor_row, output, ROW_BITS: current cursor row, for cursor display.
REQ-014 SHALL have port cursor_col, output, COL_BITS: current cursor column.

Function
REQ-015 SHALL implement states CLR_SCREEN, IDLE and CLR_LINE; all outputs SHALL be registered.
REQ-016 in_ready SHALL be 1 only in IDLE; a character SHALL be accepted on a cycle where in_valid=1 and in_ready=1, and no other.
REQ-017 A printable code (0x20..0x7E) SHALL produce, in the cycle after acceptance, ram_we=1, ram_addr={cursor_row, cursor_col}, ram_din=the code; the cursor SHALL then advance one column.
REQ-018 When a printable code is written at column 2**COL_BITS-1, the cursor SHALL move to column 0 of the next row and the state SHALL become CLR_LINE.
REQ-019 LF (0x0A) SHALL set the column to 0, advance the row, and enter CLR_LINE, with no character write.
REQ-020 CR (0x0D) SHALL set the column to 0, with no write and no row change.
REQ-021 BS (0x08) at column > 0 SHALL decrement the column and write 0x20 at the new position in the next cycle; at column 0 it SHALL do nothing.
REQ-022 FF (0x0C) SHALL home the cursor to (0,0) and enter CLR_SCREEN.
REQ-023 All other codes SHALL be accepted and discarded with no write and no cursor change.
REQ-024 Advancing the row from NUM_ROWS-1 SHALL wrap it to 0; there is no scrolling.
REQ-025 CLR_LINE SHALL write 0x20 to columns 0..2**COL_BITS-1 of the cursor row, one per cycle in ascending order, then return to IDLE; it takes exactly 2**COL_BITS write cycles.
REQ-026 CLR_SCREEN SHALL write 0x20 to every address {r, c} with r < NUM_ROWS, ascending, one per cycle (NUM_ROWS*2**COL_BITS cycles), then enter IDLE; rows >= NUM_ROWS SHALL never be written.
REQ-027 ram_we SHALL be 0 in every cycle not described by REQ-017, REQ-021, REQ-025 or REQ-026.
REQ-028 The cursor outputs SHALL show the post-operation position starting the cycle after acceptance.

Reset
REQ-029 While reset=1: ram_we=0, ram_addr=0, ram_din=0, in_ready=0, cursor_row=0, cursor_col=0; the state SHALL be CLR_SCREEN with its clear counter at 0.
REQ-030 The first cycle after reset deasserts SHALL write 0x20 at address 0.
REQ-031 Reset asserted mid-CLR_LINE or mid-CLR_SCREEN SHALL abort the clear and restart a full screen clear.

Verification
REQ-032 Reset, then idle -> 6144 consecutive writes of 0x20 at addresses 0..6143 in order, then in_ready=1 and cursor=(0,0).
REQ-033 Send 'A' (0x41), then 'B' -> writes 0x41 at addr 0 and 0x42 at addr 1; cursor=(0,2).
REQ-034 Send 128 'x' characters from (0,0) -> last write at addr 127, then 128 clears at addrs 128..255 with in_ready=0 throughout, then cursor=(1,0) and in_ready=1.
REQ-035 Cursor at (47,5), send LF -> 128 clears at addrs 0..127, then cursor=(0,0).
REQ-036 Cursor at (3,0), send BS -> no write and cursor unchanged; then send 'Q', then BS -> 0x51 at addr 384, then 0x20 at addr 384, cursor=(3,0).
REQ-037 Hold in_valid=1 with 0x07, then assert reset during a CLR_LINE -> 0x07 produces no write; after reset a full 6144-write clear starts at address 0.

Source files
------------

// File: rtl/text_console_writer.sv
// Character-stream writer for a text-mode RAM: prints characters at the cursor,
// handles LF/CR/BS/FF, and clears lines or the whole screen by writing spaces.
module text_console_writer #(
    parameter int COL_BITS   = 7,
    parameter int ROW_BITS   = 6,
    parameter int NUM_ROWS   = 48,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_char,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         ram_we,
    output logic [ROW_BITS+COL_BITS-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]        ram_din,
    output logic [ROW_BITS-1:0]          cursor_row,
    output logic [COL_BITS-1:0]          cursor_col
);

    localparam int ADDR_W = ROW_BITS + COL_BITS;
    localparam logic [COL_BITS-1:0]   COL_LAST    = '1;
    localparam logic [ROW_BITS-1:0]   ROW_LAST    = ROW_BITS'(NUM_ROWS - 1);
    localparam logic [ADDR_W-1:0]     SCREEN_LAST = {ROW_LAST, COL_LAST};
    localparam logic [DATA_WIDTH-1:0] C_SPACE     = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] C_TILDE     = DATA_WIDTH'(8'h7E);
    localparam logic [DATA_WIDTH-1:0] C_BS        = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0] C_LF        = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] C_FF        = DATA_WIDTH'(8'h0C);
    localparam logic [DATA_WIDTH-1:0] C_CR        = DATA_WIDTH'(8'h0D);

    typedef enum logic [1:0] {
        CLR_SCREEN,
        IDLE,
        CLR_LINE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [ROW_BITS-1:0] next_row;
    logic [COL_BITS-1:0] col_dec;
    logic                accept;
    logic                printable;

    assign next_row  = (cursor_row == ROW_LAST) ? '0 : cursor_row + 1'b1;
    assign col_dec   = cursor_col - 1'b1;
    assign accept    = in_valid && in_ready;
    assign printable = (in_char >= C_SPACE) && (in_char <= C_TILDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLR_SCREEN;
            clr_cnt    <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            in_ready   <= 1'b0;
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                CLR_SCREEN: begin
                    ram_we   <= 1'b1;
                    ram_addr <= clr_cnt;
                    ram_din  <= C_SPACE;
                    clr_cnt  <= clr_cnt + 1'b1;
                    if (clr_cnt == SCREEN_LAST) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                CLR_LINE: begin
                    ram_we   <= 1'b1;
                    ram_addr <= {cursor_row, clr_cnt[COL_BITS-1:0]};
                    ram_din  <= C_SPACE;
                    clr_cnt  <= clr_cnt + 1'b1;
                    if (clr_cnt[COL_BITS-1:0] == COL_LAST) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            ram_we   <= 1'b1;
                            ram_addr <= {cursor_row, cursor_col};
                            ram_din  <= in_char;
                            if (cursor_col == COL_LAST) begin
                                // Wrapping onto a new row clears that row first.
                                cursor_col <= '0;
                                cursor_row <= next_row;
                                state      <= CLR_LINE;
                                clr_cnt    <= '0;
                                in_ready   <= 1'b0;
                            end else begin
                                cursor_col <= cursor_col + 1'b1;
                            end
                        end else if (in_char == C_LF) begin
                            cursor_col <= '0;
                            cursor_row <= next_row;
                            state      <= CLR_LINE;
                            clr_cnt    <= '0;
                            in_ready   <= 1'b0;
                        end else if (in_char == C_CR) begin
                            cursor_col <= '0;
                        end else if (in_char == C_BS) begin
                            if (cursor_col != '0) begin
                                cursor_col <= col_dec;
                                ram_we     <= 1'b1;
                                ram_addr   <= {cursor_row, col_dec};
                                ram_din    <= C_SPACE;
                            end
                        end else if (in_char == C_FF) begin
                            cursor_row <= '0;
                            cursor_col <= '0;
                            state      <= CLR_SCREEN;
                            clr_cnt    <= '0;
                            in_ready   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= CLR_SCREEN;
                    clr_cnt  <= '0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: a console model predicts every RAM
// write and the cursor; a monitor matches each observed write against the queue.
module tb_text_console_writer;

    localparam int COLS = 128;
    localparam int ROWS = 48;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_char = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_din;
    logic [5:0]  cursor_row;
    logic [6:0]  cursor_col;

    text_console_writer dut (
        .clk        (clk),
        .reset      (reset),
        .in_char    (in_char),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  m_row = 0;
    int  m_col = 0;

    // Monitor: every observed write must be the next predicted one.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write", ram_addr, ram_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (int'(ram_addr) != e.addr || int'(ram_din) != e.data) begin
                    n_bad++;
                    $display("FAIL ram_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             ram_addr, ram_din, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_wr(input int addr, input int data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic model_clear_row(input int r);
        for (int c = 0; c < COLS; c++) push_wr(r * COLS + c, 8'h20);
    endtask

    task automatic model_clear_screen();
        for (int a = 0; a < ROWS * COLS; a++) push_wr(a, 8'h20);
    endtask

    task automatic model_newline();
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        model_clear_row(m_row);
    endtask

    // Console behaviour in plain terms: what the screen should receive per character.
    task automatic model_char(input int c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_wr(m_row * COLS + m_col, c);
            if (m_col == COLS - 1) model_newline();
            else m_col++;
        end else if (c == 8'h0A) begin
            model_newline();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(m_row * COLS + m_col, 8'h20);
            end
        end else if (c == 8'h0C) begin
            m_row = 0;
            m_col = 0;
            model_clear_screen();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int t = 0;
        while (in_ready !== 1'b1 && t < budget) begin
            tick();
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: in_ready never rose within %0d cycles", name, budget);
        end
    endtask

    task automatic send(input int c);
        in_char  = 8'(c);
        in_valid = 1'b1;
        wait_ready("send_wait", 8000);
        model_char(c);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_cursor(input string name);
        check({name, "_row"}, int'(cursor_row), m_row);
        check({name, "_col"}, int'(cursor_col), m_col);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, int'({ram_we, ram_addr, ram_din, in_ready, cursor_row, cursor_col}), 0);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 8000) begin
            tick();
            t++;
        end
        tick();
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    int r;
    int c;
    int lo;

    initial begin
        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset_outputs");
        m_row = 0;
        m_col = 0;
        model_clear_screen();
        reset = 1'b0;
        wait_ready("initial_clear", 7000);
        drain("initial_clear");
        check_cursor("after_clear");

        // 'A', 'B'
        send(8'h41);
        send(8'h42);
        drain("ab");
        check_cursor("ab");

        // Full row of 'x' from (0,0): wrap and line clear with in_ready low
        send(8'h0D);
        for (int i = 0; i < COLS; i++) send(8'h78);
        lo = 0;
        while (in_ready !== 1'b1 && lo < 1000) begin
            lo++;
            tick();
        end
        check("wrap_ready_low_cycles", lo, COLS);
        drain("wrap");
        check_cursor("wrap");

        // Walk to (47,5), then LF wraps to row 0
        for (int i = 0; i < ROWS - 2; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61 + i);
        drain("to_47_5");
        check("at_47_row", int'(cursor_row), 47);
        check("at_47_col", int'(cursor_col), 5);
        send(8'h0A);
        drain("lf_wrap");
        check_cursor("lf_wrap");

        // Backspace at column 0, then 'Q' and backspace on row 3
        for (int i = 0; i < 3; i++) send(8'h0A);
        drain("to_row3");
        send(8'h08);
        repeat (3) tick();
        check("bs_col0_pending", exp_q.size(), 0);
        check_cursor("bs_col0");
        send(8'h51);
        send(8'h08);
        drain("q_bs");
        check_cursor("q_bs");

        // Randomized character stream
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 78)      c = int'($urandom_range(32, 126));
            else if (r < 84) c = 8'h0A;
            else if (r < 89) c = 8'h0D;
            else if (r < 96) c = 8'h08;
            else if (r < 98) c = int'($urandom_range(127, 255));
            else             c = 8'h07;
            send(c);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain("random");
        check_cursor("random");

        // Form feed
        send(8'h0C);
        drain("ff");
        check_cursor("ff");

        // BEL held valid, then reset in the middle of a line clear
        send(8'h07);
        repeat (2) tick();
        check("bel_no_write", exp_q.size(), 0);
        send(8'h0A);
        repeat (20) tick();
        in_char  = 8'h07;
        in_valid = 1'b1;
        reset    = 1'b1;
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        repeat (3) tick();
        check_reset_outputs("midclear_reset_outputs");
        model_clear_screen();
        reset = 1'b0;
        wait_ready("reset_clear", 7000);
        drain("reset_clear");
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check_cursor("reset_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
